// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive framer with start-edge re-phase pulse,
// mid-bit sampling, data_ready/framing_error strobes and break handling.
module uart_receiver #(
  parameter int DATA_BITS   = 8,
  parameter int SAMPLE_RATE = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  input  logic                 tick_i,
  output logic                 start_rx_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 data_ready_o,
  output logic                 framing_error_o,
  output logic                 busy_o
);
  localparam int TW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID  = TW'(SAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t               state_q;
  logic                 rx_meta_q, rx_s_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  assign busy_o = state_q != IDLE;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      data_o          <= '0;
      start_rx_o      <= 1'b0;
      data_ready_o    <= 1'b0;
      framing_error_o <= 1'b0;
    end else begin
      rx_meta_q       <= rx_i;
      rx_s_q          <= rx_meta_q;
      start_rx_o      <= 1'b0;
      data_ready_o    <= 1'b0;
      framing_error_o <= 1'b0;
      case (state_q)
        IDLE: if (!rx_s_q) begin
          start_rx_o <= 1'b1;
          state_q    <= START;
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
        end
        START: if (tick_i) begin
          if (tick_cnt_q == MID) begin
            // A high line at mid start bit is a glitch, not a frame.
            state_q    <= rx_s_q ? IDLE : DATA;
            tick_cnt_q <= '0;
          end else tick_cnt_q <= tick_cnt_q + 1'b1;
        end
        DATA: if (tick_i) begin
          if (tick_cnt_q == LAST) begin
            shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_cnt_q <= '0;
            if (bit_cnt_q == BLAST) begin
              state_q   <= STOP;
              bit_cnt_q <= '0;
            end else bit_cnt_q <= bit_cnt_q + 1'b1;
          end else tick_cnt_q <= tick_cnt_q + 1'b1;
        end
        STOP: if (tick_i) begin
          if (tick_cnt_q == LAST) begin
            tick_cnt_q <= '0;
            if (rx_s_q) begin
              data_o       <= shift_q;
              data_ready_o <= 1'b1;
              state_q      <= IDLE;
            end else begin
              framing_error_o <= 1'b1;
              state_q         <= BRK;
            end
          end else tick_cnt_q <= tick_cnt_q + 1'b1;
        end
        BRK: if (rx_s_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frames against a frame-level model (counts of
// expected start/ready/error strobes and last good byte), plus directed corner cases.
module tb_uart_receiver;
  logic       clock = 1'b0, reset = 1'b1, rx = 1'b1, tick = 1'b0;
  logic       start_rx, data_ready, framing_error, busy;
  logic [7:0] data;
  int n_checks = 0, n_errors = 0;
  int n_start = 0, n_ready = 0, n_ferr = 0, n_both = 0;
  int e_start = 0, e_ready = 0, e_ferr = 0;
  logic [7:0] e_data = 8'h00, last_ready = 8'h00;
  uart_receiver #(.DATA_BITS(8), .SAMPLE_RATE(16)) dut (
    .clock_i(clock), .reset_i(reset), .rx_i(rx), .tick_i(tick),
    .start_rx_o(start_rx), .data_o(data), .data_ready_o(data_ready),
    .framing_error_o(framing_error), .busy_o(busy)
  );
  always #5 clock = ~clock;
  initial begin
    int c = 0;
    forever begin
      @(negedge clock);
      tick = (c == 3);
      c = (c + 1) % 4;
    end
  end
  always @(negedge clock) if (!reset) begin
    if (start_rx) n_start++;
    if (data_ready) begin n_ready++; last_ready = data; end
    if (framing_error) n_ferr++;
    if (data_ready && framing_error) n_both++;
  end
  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clocks(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0; clocks(64);
    for (int i = 0; i < 8; i++) begin rx = b[i]; clocks(64); end
    rx = stop; clocks(64);
  endtask
  task automatic model_frame(input logic [7:0] b, input logic stop);
    e_start++;
    if (stop) begin e_ready++; e_data = b; end
    else e_ferr++;
  endtask
  task automatic check_all(input string tag);
    check({tag, "_start"}, n_start, e_start);
    check({tag, "_ready"}, n_ready, e_ready);
    check({tag, "_ferr"}, n_ferr, e_ferr);
    check({tag, "_data"}, {24'h0, data}, {24'h0, e_data});
  endtask
  initial begin
    logic [7:0] b;
    logic       s;
    clocks(3);
    reset = 1'b0;
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    clocks(50);
    check_all("idle");
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    clocks(4);
    check_all("a5");
    check("a5_busy", {31'h0, busy}, 32'h0);
    rx = 1'b0; clocks(12); rx = 1'b1;
    e_start++;
    clocks(100);
    check_all("false_start");
    check("fs_busy", {31'h0, busy}, 32'h0);
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    clocks(160);
    check_all("break");
    check("break_busy", {31'h0, busy}, 32'h1);
    rx = 1'b1; clocks(100);
    check_all("break_end");
    check("break_idle", {31'h0, busy}, 32'h0);
    send_frame(8'h00, 1'b1);
    model_frame(8'h00, 1'b1);
    check("b2b_first", {24'h0, last_ready}, 32'h00);
    send_frame(8'hFF, 1'b1);
    model_frame(8'hFF, 1'b1);
    check("b2b_second", {24'h0, last_ready}, 32'hFF);
    check_all("b2b");
    b = 8'h96;
    rx = 1'b0; clocks(64);
    for (int i = 0; i < 3; i++) begin rx = b[i]; clocks(64); end
    rx = b[3]; clocks(32);
    e_start++;
    check("mid_busy", {31'h0, busy}, 32'h1);
    @(posedge clock); #2 reset = 1'b1;
    @(negedge clock);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_data", {24'h0, data}, 32'h0);
    check("mrst_pulses", {29'h0, start_rx, data_ready, framing_error}, 32'h0);
    e_data = 8'h00;
    rx = 1'b1; clocks(2);
    reset = 1'b0; clocks(100);
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    check_all("after_rst");
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s);
      model_frame(b, s);
      check_all("rnd");
      if (s) begin
        check("rnd_rdata", {24'h0, last_ready}, {24'h0, b});
        clocks($urandom_range(0, 80));
      end else begin
        clocks(4 * $urandom_range(10, 40));
        check("rnd_brk_start", n_start, e_start);
        rx = 1'b1; clocks(128);
        check("rnd_brk_idle", {31'h0, busy}, 32'h0);
      end
    end
    check("exclusive", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
